// File: rtl/fc_mac_stream_if.sv
// rtl/fc_mac_stream_if.sv - activation/weight input stream and result output stream of fc_mac_stream
interface fc_mac_stream_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int AW    = 23
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x_in;
  logic [NCH*WIDTH-1:0] w_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*AW-1:0]    z;

  modport master (
    output in_valid, x_in, w_in, out_ready,
    input  in_ready, out_valid, z
  );

  modport slave (
    input  in_valid, x_in, w_in, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/fc_mac_stream.sv
// rtl/fc_mac_stream.sv - time-multiplexed FC layer: NCH signed MAC channels, IN beats per frame,
// optional ReLU, result held on a valid/ready output until taken.
module fc_mac_stream #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int NCH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            relu_en,
  fc_mac_stream_if.slave  bus
);
  localparam int AW = 2*WIDTH + $clog2(IN);
  localparam int CW = $clog2(IN);

  typedef enum logic {ACC, OUT} state_t;

  state_t                   state, state_nxt;
  logic                     run;
  logic [CW-1:0]            cnt;
  logic signed [AW-1:0]     acc  [NCH];
  logic signed [2*WIDTH-1:0] prod [NCH];
  logic signed [AW-1:0]     sum  [NCH];
  logic [NCH*AW-1:0]        z_q;
  logic                     accept;
  logic                     last;

  // run holds in_ready low while reset is asserted and for nothing else
  assign accept = bus.in_valid && run && (state == ACC);
  assign last   = (cnt == CW'(IN-1));
  assign bus.z  = z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ACC: begin
        bus.in_ready = run;
        if (accept && !clear && last) state_nxt = OUT;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      prod[c] = $signed(bus.x_in) * $signed(bus.w_in[c*WIDTH +: WIDTH]);
      sum[c]  = acc[c] + AW'(prod[c]);
    end
  end

  // clear wins over a beat offered in the same cycle; OUT ignores clear entirely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      z_q <= '0;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
    end else if (state == ACC) begin
      if (clear) begin
        cnt <= '0;
        for (int c = 0; c < NCH; c++) acc[c] <= '0;
      end else if (accept) begin
        if (last) begin
          cnt <= '0;
          for (int c = 0; c < NCH; c++) begin
            acc[c]            <= '0;
            z_q[c*AW +: AW]   <= (relu_en && sum[c][AW-1]) ? '0 : sum[c];
          end
        end else begin
          cnt <= cnt + CW'(1);
          for (int c = 0; c < NCH; c++) acc[c] <= sum[c];
        end
      end
    end
  end
endmodule

// File: tb/tb_fc_mac_stream.sv
// tb/tb_fc_mac_stream.sv - directed bench for fc_mac_stream: small IN=4/NCH=2 instance and a
// default-parameter instance for full-range accumulation.
module tb_fc_mac_stream;
  logic clk = 1'b0;
  logic rst_n;
  logic clear_a, relu_a, clear_b, relu_b;
  int   checks = 0;
  int   errors = 0;

  fc_mac_stream_if #(.WIDTH(8), .NCH(2), .AW(18)) ifa ();
  fc_mac_stream_if #(.WIDTH(8), .NCH(4), .AW(23)) ifb ();

  fc_mac_stream #(.WIDTH(8), .IN(4), .NCH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_a), .relu_en(relu_a), .bus(ifa)
  );
  fc_mac_stream #(.WIDTH(8), .IN(128), .NCH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b), .relu_en(relu_b), .bus(ifb)
  );

  always #5 clk = ~clk;

  logic signed [17:0] za0, za1;
  logic signed [22:0] zb0, zb3;
  assign za0 = ifa.z[17:0];
  assign za1 = ifa.z[35:18];
  assign zb0 = ifb.z[22:0];
  assign zb3 = ifb.z[91:69];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat_a(input logic [7:0] x, input logic [7:0] w0, input logic [7:0] w1);
    ifa.in_valid = 1'b1;
    ifa.x_in     = x;
    ifa.w_in     = {w1, w0};
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic frame_a();
    for (int i = 1; i <= 4; i++) beat_a(8'(i), 8'h01, 8'hff);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_a = 1'b0; relu_a = 1'b0; clear_b = 1'b0; relu_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.x_in = '0; ifa.w_in = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.x_in = '0; ifb.w_in = '0; ifb.out_ready = 1'b1;

    #12;
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_z0", za0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", ifa.in_ready, 1);

    // T1
    for (int i = 1; i <= 3; i++) beat_a(8'(i), 8'h01, 8'hff);
    chk("t1_no_early_valid", ifa.out_valid, 0);
    beat_a(8'd4, 8'h01, 8'hff);
    chk("t1_out_valid", ifa.out_valid, 1);
    chk("t1_in_ready_out", ifa.in_ready, 0);
    chk("t1_z0", za0, 10);
    chk("t1_z1", za1, -10);
    @(posedge clk); #1;
    chk("t1_valid_one_cycle", ifa.out_valid, 0);
    chk("t1_in_ready_back", ifa.in_ready, 1);
    chk("t1_z0_kept", za0, 10);

    // T2: relu on final beat clamps the negative channel
    relu_a = 1'b1;
    frame_a();
    chk("t2_z0", za0, 10);
    chk("t2_z1", za1, 0);
    @(posedge clk); #1;

    // relu only sampled at final beat
    for (int i = 1; i <= 3; i++) beat_a(8'(i), 8'h01, 8'hff);
    relu_a = 1'b0;
    beat_a(8'd4, 8'h01, 8'hff);
    chk("t2b_z1_relu_late_off", za1, -10);
    @(posedge clk); #1;

    // T3: back-pressure
    ifa.out_ready = 1'b0;
    frame_a();
    for (int i = 0; i < 5; i++) begin
      ifa.in_valid = 1'b1; ifa.x_in = 8'd9; ifa.w_in = {8'd7, 8'd7};
      chk("t3_hold_valid", ifa.out_valid, 1);
      chk("t3_hold_in_ready", ifa.in_ready, 0);
      chk("t3_hold_z0", za0, 10);
      chk("t3_hold_z1", za1, -10);
      @(posedge clk); #1;
    end
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_released", ifa.out_valid, 0);
    frame_a();
    chk("t3_next_z0", za0, 10);
    chk("t3_next_z1", za1, -10);
    @(posedge clk); #1;

    // T4: clear mid-frame drops partial sums and the same-cycle beat
    beat_a(8'd5, 8'd3, 8'd3);
    beat_a(8'd5, 8'd3, 8'd3);
    clear_a = 1'b1;
    ifa.in_valid = 1'b1; ifa.x_in = 8'd7; ifa.w_in = {8'd1, 8'd1};
    @(posedge clk); #1;
    clear_a = 1'b0; ifa.in_valid = 1'b0;
    frame_a();
    chk("t4_out_valid", ifa.out_valid, 1);
    chk("t4_z0", za0, 10);
    chk("t4_z1", za1, -10);
    @(posedge clk); #1;

    // clear while result pending is ignored
    ifa.out_ready = 1'b0;
    beat_a(8'd2, 8'd2, 8'd2);
    beat_a(8'd2, 8'd2, 8'd2);
    beat_a(8'd2, 8'd2, 8'd2);
    beat_a(8'd2, 8'd2, 8'hfe);
    clear_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0;
    chk("t4_clear_out_valid", ifa.out_valid, 1);
    chk("t4_clear_out_z0", za0, 16);
    chk("t4_clear_out_z1", za1, 8);
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_clear_out_taken", ifa.out_valid, 0);

    // T5: full-range accumulation, default parameters
    for (int i = 0; i < 128; i++) begin
      ifb.in_valid = 1'b1; ifb.x_in = 8'h80; ifb.w_in = {4{8'h80}};
      @(posedge clk); #1;
    end
    ifb.in_valid = 1'b0;
    chk("t5_out_valid", ifb.out_valid, 1);
    chk("t5_z0_max", zb0, 2097152);
    chk("t5_z3_max", zb3, 2097152);
    @(posedge clk); #1;
    for (int i = 0; i < 128; i++) begin
      ifb.in_valid = 1'b1; ifb.x_in = 8'h80; ifb.w_in = {4{8'h7f}};
      @(posedge clk); #1;
    end
    ifb.in_valid = 1'b0;
    chk("t5_z0_min", zb0, -2080768);
    chk("t5_z3_min", zb3, -2080768);
    @(posedge clk); #1;

    // T6: async reset mid-frame
    beat_a(8'd1, 8'h01, 8'hff);
    beat_a(8'd2, 8'h01, 8'hff);
    rst_n = 1'b0;
    #1;
    chk("t6_mid_frame_valid", ifa.out_valid, 0);
    chk("t6_mid_frame_in_ready", ifa.in_ready, 0);
    chk("t6_mid_frame_z0", za0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // async reset while result pending
    ifa.out_ready = 1'b0;
    frame_a();
    chk("t6_pre_valid", ifa.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_mid_out_valid", ifa.out_valid, 0);
    chk("t6_mid_out_z0", za0, 0);
    chk("t6_mid_out_z1", za1, 0);
    #2 rst_n = 1'b1;
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    frame_a();
    chk("t6_after_valid", ifa.out_valid, 1);
    chk("t6_after_z0", za0, 10);
    chk("t6_after_z1", za1, -10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
